// File: rtl/cfg_pkg.sv
// Shared definitions for the neuron configuration stream loader:
// command codes, header field positions and FSM state encoding.
package cfg_pkg;

    localparam logic [3:0] CMD_LOAD = 4'h1;
    localparam logic [3:0] CMD_END  = 4'hF;

    // Header word layout: [31:28] cmd, [27:20] layer, [19:10] neuron, [9:0] count
    localparam int HDR_CMD_MSB    = 31;
    localparam int HDR_CMD_LSB    = 28;
    localparam int HDR_LAYER_MSB  = 27;
    localparam int HDR_LAYER_LSB  = 20;
    localparam int HDR_NEURON_MSB = 19;
    localparam int HDR_NEURON_LSB = 10;
    localparam int HDR_COUNT_MSB  = 9;
    localparam int HDR_COUNT_LSB  = 0;

    typedef enum logic [2:0] {
        IDLE_WAIT = 3'd0,
        HDR       = 3'd1,
        WGT       = 3'd2,
        BIAS      = 3'd3,
        CHK       = 3'd4,
        DONE      = 3'd5
    } state_t;

endpackage

// File: rtl/cfg_stream_loader.sv
// Drives the broadcast neuron weight/bias config bus from a 32-bit header/data stream.
// Define CFG_CHECKSUM_EN to require an XOR checksum trailer after each LOAD record.
module cfg_stream_loader
    import cfg_pkg::*;
#(
    parameter int dataWidth  = 16,
    parameter int numLayers  = 8,
    parameter int maxNeurons = 1024,
    parameter int maxWeights = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] weightValue,
    output logic        weightValid,
    output logic [31:0] biasValue,
    output logic        biasValid,
    output logic [31:0] config_layer_num,
    output logic [31:0] config_neuron_num,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // Weight/bias words pass through untouched; only the width bound is enforced here.
    if (dataWidth < 1 || dataWidth > 32) begin : g_bad_data_width
        $error("cfg_stream_loader: dataWidth must be in 1..32");
    end
    if (maxWeights < 1 || maxWeights > 1023) begin : g_bad_max_weights
        $error("cfg_stream_loader: maxWeights must fit the 10-bit count field");
    end

    state_t      state;
    logic [9:0]  remaining;
    logic        transfer;
    logic [3:0]  hdr_cmd;
    logic [7:0]  hdr_layer;
    logic [9:0]  hdr_neuron;
    logic [9:0]  hdr_count;
    logic        hdr_load_ok;

    assign hdr_cmd    = s_data[HDR_CMD_MSB:HDR_CMD_LSB];
    assign hdr_layer  = s_data[HDR_LAYER_MSB:HDR_LAYER_LSB];
    assign hdr_neuron = s_data[HDR_NEURON_MSB:HDR_NEURON_LSB];
    assign hdr_count  = s_data[HDR_COUNT_MSB:HDR_COUNT_LSB];

    assign hdr_load_ok = (hdr_cmd == CMD_LOAD)
                       && ({24'd0, hdr_layer} < numLayers)
                       && ({22'd0, hdr_neuron} < maxNeurons)
                       && (hdr_count != 10'd0)
                       && ({22'd0, hdr_count} <= maxWeights);

    assign s_ready  = (state == HDR) || (state == WGT) || (state == BIAS) || (state == CHK);
    assign busy     = s_ready;
    assign transfer = s_valid && s_ready;

`ifdef CFG_CHECKSUM_EN
    logic [31:0] csum;
`endif

    // Single FSM: strobes default low each cycle so upstream bubbles become gaps on the bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE_WAIT;
            remaining         <= 10'd0;
            weightValue       <= 32'd0;
            weightValid       <= 1'b0;
            biasValue         <= 32'd0;
            biasValid         <= 1'b0;
            config_layer_num  <= 32'd0;
            config_neuron_num <= 32'd0;
            done              <= 1'b0;
            err               <= 1'b0;
`ifdef CFG_CHECKSUM_EN
            csum              <= 32'd0;
`endif
        end else begin
            weightValid <= 1'b0;
            biasValid   <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE_WAIT, DONE: begin
                    if (start) begin
                        state <= HDR;
                        err   <= 1'b0;
                    end
                end
                HDR: begin
                    if (transfer) begin
                        if (hdr_load_ok) begin
                            config_layer_num  <= {24'd0, hdr_layer};
                            config_neuron_num <= {22'd0, hdr_neuron};
                            remaining         <= hdr_count;
                            state             <= WGT;
`ifdef CFG_CHECKSUM_EN
                            csum              <= s_data;
`endif
                        end else if (hdr_cmd == CMD_END) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                WGT: begin
                    if (transfer) begin
                        weightValue <= s_data;
                        weightValid <= 1'b1;
                        remaining   <= remaining - 10'd1;
`ifdef CFG_CHECKSUM_EN
                        csum        <= csum ^ s_data;
`endif
                        if (remaining == 10'd1) begin
                            state <= BIAS;
                        end
                    end
                end
                BIAS: begin
                    if (transfer) begin
                        biasValue <= s_data;
                        biasValid <= 1'b1;
`ifdef CFG_CHECKSUM_EN
                        csum      <= csum ^ s_data;
                        state     <= CHK;
`else
                        state     <= HDR;
`endif
                    end
                end
`ifdef CFG_CHECKSUM_EN
                // Strobes already went out; a bad trailer only raises the sticky error.
                CHK: begin
                    if (transfer) begin
                        if (s_data != csum) begin
                            err <= 1'b1;
                        end
                        state <= HDR;
                    end
                end
`endif
                default: begin
                    state <= IDLE_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Scoreboard bench for cfg_stream_loader: stimulus pushes expected bus events,
// a negedge monitor pops and compares them as strobes appear.
module tb_cfg_stream_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] weightValue;
    logic        weightValid;
    logic [31:0] biasValue;
    logic        biasValid;
    logic [31:0] config_layer_num;
    logic [31:0] config_neuron_num;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    cfg_stream_loader dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .s_data           (s_data),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .weightValue      (weightValue),
        .weightValid      (weightValid),
        .biasValue        (biasValue),
        .biasValid        (biasValid),
        .config_layer_num (config_layer_num),
        .config_neuron_num(config_neuron_num),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    typedef struct {
        int          kind;
        logic [31:0] value;
        logic [31:0] layer;
        logic [31:0] neuron;
    } ev_t;

    localparam int EV_WEIGHT = 0;
    localparam int EV_BIAS   = 1;
    localparam int EV_DONE   = 2;

    ev_t         exp_q[$];
    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [15:0] wv_hist      = 16'd0;
    logic [31:0] wbuf [4];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_compared++;
        if (act !== expv) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Drive one word and hold it until the loader has taken it.
    task automatic apply_stimulus(input logic [31:0] word);
        logic rdy;
        int   guard;
        guard   = 0;
        s_data  = word;
        s_valid = 1'b1;
        forever begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            guard++;
            if (guard > 20) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL s_ready_timeout: s_ready=0 for 20 cycles, expected 1");
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        idle_cycle();
        start = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] hdr, input int n, input logic [31:0] bias, input bit gaps);
        logic [31:0] lay;
        logic [31:0] neu;
        logic [31:0] cs;
        lay = {24'd0, hdr[27:20]};
        neu = {22'd0, hdr[19:10]};
        cs  = hdr;
        apply_stimulus(hdr);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{EV_WEIGHT, wbuf[i], lay, neu});
            apply_stimulus(wbuf[i]);
            cs = cs ^ wbuf[i];
            if (gaps && i != n - 1) idle_cycle();
        end
        if (gaps) begin
            idle_cycle();
            check_output("wv_gap_pattern", {26'd0, wv_hist[5:0]}, 32'h15);
        end
        exp_q.push_back('{EV_BIAS, bias, lay, neu});
        apply_stimulus(bias);
        cs = cs ^ bias;
`ifdef CFG_CHECKSUM_EN
        apply_stimulus(cs);
`endif
    endtask

    task automatic expect_end();
        exp_q.push_back('{EV_DONE, 32'd0, 32'd0, 32'd0});
        apply_stimulus(32'hF000_0000);
    endtask

    // Monitor: every strobe or done pulse must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        int  k;
        ev_t e;
        if (rst) begin
            wv_hist = {wv_hist[14:0], weightValid};
            check_output("strobe_exclusive", 32'(weightValid & biasValid), 32'd0);
            if (weightValid || biasValid || done) begin
                k = weightValid ? EV_WEIGHT : (biasValid ? EV_BIAS : EV_DONE);
                if (exp_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_event: got kind %0d expected no event", k);
                end else begin
                    e = exp_q.pop_front();
                    check_output("sb_kind", 32'(k), 32'(e.kind));
                    if (k == EV_WEIGHT) check_output("sb_weight", weightValue, e.value);
                    if (k == EV_BIAS) check_output("sb_bias", biasValue, e.value);
                    if (k != EV_DONE) begin
                        check_output("sb_layer", config_layer_num, e.layer);
                        check_output("sb_neuron", config_neuron_num, e.neuron);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_s_ready", 32'(s_ready), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_err", 32'(err), 32'd0);
        check_output("rst_weightValid", 32'(weightValid), 32'd0);
        check_output("rst_biasValid", 32'(biasValid), 32'd0);
        check_output("rst_weightValue", weightValue, 32'd0);
        check_output("rst_biasValue", biasValue, 32'd0);
        check_output("rst_layer", config_layer_num, 32'd0);
        check_output("rst_neuron", config_neuron_num, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle_cycle();
        check_output("idle_s_ready", 32'(s_ready), 32'd0);
        pulse_start();
        check_output("start_s_ready", 32'(s_ready), 32'd1);
        check_output("start_busy", 32'(busy), 32'd1);

        // Basic load: layer 1, neuron 2, three weights.
        wbuf = '{32'h11, 32'h22, 32'h33, 32'h0};
        do_load(32'h1010_0803, 3, 32'h44, 1'b0);
        check_output("load1_err", 32'(err), 32'd0);
        check_output("load1_layer_hold", config_layer_num, 32'd1);
        check_output("load1_neuron_hold", config_neuron_num, 32'd2);

        // Upstream bubbles between weights: layer 3, neuron 5.
        wbuf = '{32'hA1, 32'hA2, 32'hA3, 32'h0};
        do_load(32'h1030_1403, 3, 32'hB0, 1'b1);
        check_output("load2_err", 32'(err), 32'd0);

        // Illegal command, then a start that must be ignored mid-stream.
        apply_stimulus(32'h7000_0000);
        check_output("bad_cmd_err", 32'(err), 32'd1);
        check_output("bad_cmd_layer_hold", config_layer_num, 32'd3);
        check_output("bad_cmd_neuron_hold", config_neuron_num, 32'd5);
        pulse_start();
        check_output("start_ignored_err", 32'(err), 32'd1);
        check_output("start_ignored_busy", 32'(busy), 32'd1);

        // Neuron at the top of its range, single weight.
        wbuf = '{32'h5555_0001, 32'h0, 32'h0, 32'h0};
        do_load(32'h100F_FC01, 1, 32'hDEAD_BEEF, 1'b0);
        check_output("after_bad_err_sticky", 32'(err), 32'd1);

        expect_end();
        check_output("end_done", 32'(done), 32'd1);
        idle_cycle();
        check_output("end_done_pulse", 32'(done), 32'd0);
        check_output("end_s_ready", 32'(s_ready), 32'd0);
        check_output("end_busy", 32'(busy), 32'd0);
        check_output("end_err_kept", 32'(err), 32'd1);
        idle_cycle();
        check_output("end_s_ready_wait", 32'(s_ready), 32'd0);
        check_output("end_layer_hold", config_layer_num, 32'd0);
        check_output("end_neuron_hold", config_neuron_num, 32'h3FF);
        pulse_start();
        check_output("restart_err_clear", 32'(err), 32'd0);
        check_output("restart_s_ready", 32'(s_ready), 32'd1);

        apply_stimulus(32'h1010_0800);
        check_output("count0_err", 32'(err), 32'd1);
        check_output("count0_layer_hold", config_layer_num, 32'd0);
        expect_end();
        idle_cycle();
        pulse_start();
        check_output("restart2_err_clear", 32'(err), 32'd0);
        apply_stimulus(32'h1080_0001);
        check_output("layer8_err", 32'(err), 32'd1);
        expect_end();
        idle_cycle();
        pulse_start();

        // Reset partway through a five-weight load.
        exp_q.push_back('{EV_WEIGHT, 32'hC1, 32'd2, 32'd7});
        exp_q.push_back('{EV_WEIGHT, 32'hC2, 32'd2, 32'd7});
        apply_stimulus(32'h1020_1C05);
        apply_stimulus(32'hC1);
        apply_stimulus(32'hC2);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_output("midrst_weightValid", 32'(weightValid), 32'd0);
        check_output("midrst_weightValue", weightValue, 32'd0);
        check_output("midrst_s_ready", 32'(s_ready), 32'd0);
        check_output("midrst_busy", 32'(busy), 32'd0);
        check_output("midrst_layer", config_layer_num, 32'd0);
        check_output("midrst_neuron", config_neuron_num, 32'd0);
        check_output("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle_cycle();
        pulse_start();
        wbuf = '{32'h77, 32'h88, 32'h0, 32'h0};
        do_load(32'h1040_2402, 2, 32'h99, 1'b0);
        check_output("fresh_err", 32'(err), 32'd0);
        check_output("fresh_layer", config_layer_num, 32'd4);
        check_output("fresh_neuron", config_neuron_num, 32'd9);

`ifdef CFG_CHECKSUM_EN
        // Corrupted trailer: strobes still appear, error is flagged.
        exp_q.push_back('{EV_WEIGHT, 32'h1234, 32'd5, 32'd3});
        exp_q.push_back('{EV_BIAS, 32'h5678, 32'd5, 32'd3});
        apply_stimulus(32'h1050_0C01);
        apply_stimulus(32'h1234);
        apply_stimulus(32'h5678);
        check_output("chk_good_err", 32'(err), 32'd0);
        apply_stimulus((32'h1050_0C01 ^ 32'h1234 ^ 32'h5678) ^ 32'd1);
        check_output("chk_bad_err", 32'(err), 32'd1);
        check_output("chk_back_to_hdr", 32'(s_ready), 32'd1);
`endif

        repeat (3) idle_cycle();
        check_output("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
